// File: rtl/r88_intctl.sv
// Interrupt controller for Rocket88: syncs 8 IRQ sources + NMI, edge/level pending, mask, enable, NMI pulse.
// Bus reads are combinational, writes commit at the clock edge; IRQ visible 2 edges after a level source rises, 3 for edge mode.
module r88_intctl #(
   parameter logic [15:0] BASE      = 16'hFFF0,
   parameter int unsigned NMI_WIDTH = 4
) (
   input  logic        sysClock,
   input  logic        resetReq,
   input  logic [7:0]  irqSrc,
   input  logic        nmiSrc,
   input  logic [15:0] busA,
   input  logic        readMem,
   input  logic        writeMem,
   input  logic [7:0]  busDIn,
   output logic [7:0]  busDOut,
   output logic        busDOe,
   output logic        irq,
   output logic        nmiReq
);

   localparam logic [3:0] NMI_LOAD = 4'(NMI_WIDTH);

   // bit 8 of the synchronizer vectors carries the NMI source
   logic [8:0] r_s1, r_s2, r_prev;
   logic [1:0] r_arm;
   logic [7:0] r_lat, r_mask, r_edge;
   logic       r_en, r_nmif;
   logic [3:0] r_nmi_cnt;

   logic       w_hit, w_wr;
   logic [4:0] w_wr_sel;
   logic [8:0] w_rise;
   logic [7:0] w_pend, w_act, w_vec, w_rd;

   assign w_hit  = (busA[15:3] == BASE[15:3]);
   assign w_wr   = writeMem & w_hit;
   assign w_rise = r_s2 & ~r_prev;
   assign w_pend = (r_edge & r_lat) | (~r_edge & r_s2[7:0]);
   assign w_act  = w_pend & r_mask;

   always_comb begin
      w_wr_sel = 5'b0;
      for (int k = 0; k < 5; k++)
         w_wr_sel[k] = w_wr & (busA[2:0] == 3'(k));
   end

   always_ff @(posedge sysClock) begin
      if (!resetReq) begin
         r_s1      <= '0;
         r_s2      <= '0;
         r_prev    <= '0;
         r_arm     <= '0;
         r_lat     <= '0;
         r_mask    <= '0;
         r_edge    <= '0;
         r_en      <= 1'b0;
         r_nmif    <= 1'b0;
         r_nmi_cnt <= '0;
      end else begin
         r_s1  <= {nmiSrc, irqSrc};
         r_s2  <= r_s1;
         r_arm <= {r_arm[0], 1'b1};
         // Until the pipe refills after reset, prev shadows s2 so a held source is not an edge
         r_prev <= r_arm[1] ? r_s2 : r_s1;

         r_lat <= (r_lat & ~({8{w_wr_sel[0]}} & busDIn & r_edge)) | (w_rise[7:0] & r_edge);

         if (w_wr_sel[1]) r_mask <= busDIn;
         if (w_wr_sel[2]) r_edge <= busDIn;
         if (w_wr_sel[4]) r_en   <= busDIn[0];

         r_nmif <= (r_nmif & ~(w_wr_sel[4] & busDIn[1])) | w_rise[8];

         if (w_rise[8])
            r_nmi_cnt <= NMI_LOAD;
         else if (r_nmi_cnt != 4'd0)
            r_nmi_cnt <= r_nmi_cnt - 4'd1;
      end
   end

   always_comb begin
      w_vec = 8'h80;
      for (int i = 7; i >= 0; i--)
         if (w_act[i]) w_vec = {5'b0, 3'(i)};
   end

   always_comb begin
      w_rd = 8'h00;
      case (busA[2:0])
         3'd0:    w_rd = w_pend;
         3'd1:    w_rd = r_mask;
         3'd2:    w_rd = r_edge;
         3'd3:    w_rd = w_vec;
         3'd4:    w_rd = {6'b0, r_nmif, r_en};
         default: w_rd = 8'h00;
      endcase
   end

   assign busDOe  = readMem & w_hit & resetReq;
   assign busDOut = busDOe ? w_rd : 8'h00;
   assign irq     = r_en & (|w_act);
   assign nmiReq  = (r_nmi_cnt != 4'd0);

endmodule

// File: tb/tb_r88_intctl.sv
// Bench for r88_intctl: directed scenarios plus random traffic against a history-based reference model.
module tb_r88_intctl;

   localparam logic [15:0] BASE  = 16'hFFF0;
   localparam int          NMI_W = 4;

   logic        sysClock = 1'b0;
   logic        resetReq = 1'b0;
   logic [7:0]  irqSrc   = 8'h00;
   logic        nmiSrc   = 1'b0;
   logic [15:0] busA     = 16'h0000;
   logic        readMem  = 1'b0;
   logic        writeMem = 1'b0;
   logic [7:0]  busDIn   = 8'h00;
   logic [7:0]  busDOut;
   logic        busDOe;
   logic        irq;
   logic        nmiReq;

   int n_chk  = 0;
   int n_fail = 0;

   r88_intctl #(.BASE(BASE), .NMI_WIDTH(NMI_W)) dut (
      .sysClock (sysClock),
      .resetReq (resetReq),
      .irqSrc   (irqSrc),
      .nmiSrc   (nmiSrc),
      .busA     (busA),
      .readMem  (readMem),
      .writeMem (writeMem),
      .busDIn   (busDIn),
      .busDOut  (busDOut),
      .busDOe   (busDOe),
      .irq      (irq),
      .nmiReq   (nmiReq)
   );

   always #5 sysClock = ~sysClock;

   // Reference model: last three sampled source vectors, plus architectural registers
   logic [8:0] m_hist[$];
   logic [7:0] m_lat, m_mask, m_edge;
   logic       m_en, m_nmif;
   int         m_left;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [8:0] m_s2();
      int k = m_hist.size();
      return (k >= 2) ? m_hist[k-2] : 9'h0;
   endfunction

   function automatic logic [7:0] m_pend();
      logic [8:0] s2 = m_s2();
      return (m_edge & m_lat) | (~m_edge & s2[7:0]);
   endfunction

   function automatic logic [7:0] m_vector();
      logic [7:0] a = m_pend() & m_mask;
      for (int i = 0; i < 8; i++)
         if (a[i]) return 8'(i);
      return 8'h80;
   endfunction

   function automatic logic m_hit();
      return busA[15:3] == BASE[15:3];
   endfunction

   function automatic logic [7:0] m_read();
      if (!(readMem && m_hit() && resetReq)) return 8'h00;
      case (busA[2:0])
         3'd0:    return m_pend();
         3'd1:    return m_mask;
         3'd2:    return m_edge;
         3'd3:    return m_vector();
         3'd4:    return {6'b0, m_nmif, m_en};
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_step();
      int k;
      logic [8:0] s2, prev, rise;
      logic wr;
      if (!resetReq) begin
         m_hist.delete();
         m_lat = 0; m_mask = 0; m_edge = 0;
         m_en = 0; m_nmif = 0; m_left = 0;
         return;
      end
      k    = m_hist.size();
      s2   = (k >= 2) ? m_hist[k-2] : 9'h0;
      // a source edge only counts once the synchronizer has a full history after reset
      prev = (k >= 3) ? m_hist[k-3] : s2;
      rise = s2 & ~prev;
      wr   = writeMem && m_hit();

      if (wr && busA[2:0] == 3'd0) m_lat = m_lat & ~(busDIn & m_edge);
      m_lat = m_lat | (rise[7:0] & m_edge);
      if (wr && busA[2:0] == 3'd4 && busDIn[1]) m_nmif = 1'b0;
      if (rise[8]) m_nmif = 1'b1;
      if (rise[8]) m_left = NMI_W;
      else if (m_left > 0) m_left--;
      if (wr && busA[2:0] == 3'd1) m_mask = busDIn;
      if (wr && busA[2:0] == 3'd2) m_edge = busDIn;
      if (wr && busA[2:0] == 3'd4) m_en   = busDIn[0];

      m_hist.push_back({nmiSrc, irqSrc});
      if (m_hist.size() > 3) void'(m_hist.pop_front());
   endtask

   task automatic compare_all();
      chk("irq",     16'(irq),     16'(m_en & (|(m_pend() & m_mask))));
      chk("nmiReq",  16'(nmiReq),  16'(m_left != 0));
      chk("busDOe",  16'(busDOe),  16'(readMem && m_hit() && resetReq));
      chk("busDOut", 16'(busDOut), 16'(m_read()));
   endtask

   task automatic cycle();
      @(posedge sysClock);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
      busA = a; busDIn = d; writeMem = 1'b1;
      cycle();
      writeMem = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
      busA = a; readMem = 1'b1;
      #1;
      chk(tag, 16'(busDOut), 16'(exp));
      cycle();
      readMem = 1'b0;
   endtask

   task automatic count_nmi(output int cnt);
      cnt = 0;
      while (nmiReq && cnt < 32) begin
         cnt++;
         cycle();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
      $fatal(1);
   end

   initial begin
      int cnt;

      // Reset with every source high
      irqSrc = 8'hFF; nmiSrc = 1'b1; resetReq = 1'b0;
      repeat (2) cycle();
      chk("rst_irq", 16'(irq), 16'd0);
      chk("rst_nmi", 16'(nmiReq), 16'd0);
      resetReq = 1'b1;
      rd("rst_mask", BASE + 16'd1, 8'h00);
      rd("rst_edge", BASE + 16'd2, 8'h00);
      rd("rst_ctrl", BASE + 16'd4, 8'h00);
      rd("rst_vec",  BASE + 16'd3, 8'h80);
      repeat (3) cycle();
      rd("rst_ctrl_held", BASE + 16'd4, 8'h00);
      irqSrc = 8'h00; nmiSrc = 1'b0;
      repeat (4) cycle();

      // Level source
      bus_wr(BASE + 16'd1, 8'h04);
      bus_wr(BASE + 16'd4, 8'h01);
      irqSrc = 8'h04;
      cycle();
      chk("lvl_t0", 16'(irq), 16'd0);
      cycle();
      chk("lvl_t1", 16'(irq), 16'd1);
      rd("lvl_vec", BASE + 16'd3, 8'h02);
      irqSrc = 8'h00;
      cycle();
      chk("lvl_drop_t0", 16'(irq), 16'd1);
      cycle();
      chk("lvl_drop_t1", 16'(irq), 16'd0);

      // Edge latch, W1C, set-beats-clear
      bus_wr(BASE + 16'd2, 8'hFF);
      bus_wr(BASE + 16'd1, 8'hFF);
      irqSrc = 8'h22;
      repeat (3) cycle();
      irqSrc = 8'h00;
      repeat (3) cycle();
      rd("edge_status", BASE + 16'd0, 8'h22);
      rd("edge_vec",    BASE + 16'd3, 8'h01);
      bus_wr(BASE + 16'd0, 8'h02);
      rd("w1c_vec",     BASE + 16'd3, 8'h05);
      irqSrc = 8'h20;
      repeat (2) cycle();
      bus_wr(BASE + 16'd0, 8'h20);
      rd("set_wins", BASE + 16'd0, 8'h20);
      irqSrc = 8'h00;
      repeat (2) cycle();
      bus_wr(BASE + 16'd0, 8'h20);
      chk("w1c_irq_low", 16'(irq), 16'd0);
      rd("w1c_status", BASE + 16'd0, 8'h00);

      // NMI pulse, extension, NMIF
      bus_wr(BASE + 16'd4, 8'h00);
      nmiSrc = 1'b1;
      repeat (2) cycle();
      chk("nmi_t1", 16'(nmiReq), 16'd0);
      cycle();
      chk("nmi_t2", 16'(nmiReq), 16'd1);
      nmiSrc = 1'b0;
      count_nmi(cnt);
      chk("nmi_width", 16'(cnt), 16'(NMI_W));
      rd("nmif_set", BASE + 16'd4, 8'h02);
      nmiSrc = 1'b1; cycle();
      nmiSrc = 1'b0; cycle();
      nmiSrc = 1'b1; cycle();
      count_nmi(cnt);
      chk("nmi_extend", 16'(cnt), 16'(2 + NMI_W));
      nmiSrc = 1'b0;
      bus_wr(BASE + 16'd4, 8'h02);
      rd("nmif_clr", BASE + 16'd4, 8'h00);

      // Bus decode
      busA = BASE + 16'd5; readMem = 1'b1; #1;
      chk("rd5_oe", 16'(busDOe), 16'd1);
      chk("rd5_dat", 16'(busDOut), 16'd0);
      cycle(); readMem = 1'b0;
      busA = 16'hFFE8; readMem = 1'b1; #1;
      chk("miss_oe", 16'(busDOe), 16'd0);
      chk("miss_dat", 16'(busDOut), 16'd0);
      cycle(); readMem = 1'b0;
      bus_wr(16'hFFF8, 8'h00);
      bus_wr(16'hFFF9, 8'h00);
      bus_wr(16'hFFFA, 8'h00);
      bus_wr(BASE + 16'd5, 8'hFF);
      rd("miss_wr_mask", BASE + 16'd1, 8'hFF);
      rd("miss_wr_edge", BASE + 16'd2, 8'hFF);
      rd("wr5_ignored",  BASE + 16'd5, 8'h00);

      // Reset during an NMI pulse with everything latched
      irqSrc = 8'hFF;
      repeat (4) cycle();
      rd("pre_rst_status", BASE + 16'd0, 8'hFF);
      nmiSrc = 1'b1;
      repeat (3) cycle();
      chk("pre_rst_nmi", 16'(nmiReq), 16'd1);
      resetReq = 1'b0;
      cycle();
      chk("rst_cuts_nmi", 16'(nmiReq), 16'd0);
      cycle();
      resetReq = 1'b1;
      bus_wr(BASE + 16'd2, 8'hFF);
      repeat (6) cycle();
      rd("post_rst_status", BASE + 16'd0, 8'h00);
      rd("post_rst_ctrl",   BASE + 16'd4, 8'h00);
      chk("post_rst_nmi", 16'(nmiReq), 16'd0);
      irqSrc = 8'h00; nmiSrc = 1'b0;
      repeat (4) cycle();

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         readMem = 1'b0; writeMem = 1'b0;
         resetReq = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
         if ($urandom_range(0, 7) == 0) irqSrc = 8'($urandom);
         if ($urandom_range(0, 15) == 0) nmiSrc = ~nmiSrc;
         case ($urandom_range(0, 7))
            0, 1, 2: begin busA = BASE | 16'($urandom_range(0, 7)); readMem = 1'b1; end
            3:       begin busA = BASE | 16'($urandom_range(0, 4)); busDIn = 8'($urandom); writeMem = 1'b1; end
            4:       begin busA = 16'($urandom); readMem = 1'b1; end
            default: ;
         endcase
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
